// File: rtl/delay_pkg.sv
// -----------------------------------------------------------------------------
// delay_pkg
// Shared constants and helpers for the delay receive path.
//   DEFAULT_SIG_DATA_WIDTH : default payload width in bits
//   DEFAULT_DEPTH          : default FIFO depth in entries
//   ptr_width()            : pointer width (address bits) for a given depth
// -----------------------------------------------------------------------------
package delay_pkg;

    localparam int DEFAULT_SIG_DATA_WIDTH = 16;
    localparam int DEFAULT_DEPTH          = 8;

    // Address bits needed to index 'depth' entries; never less than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage : delay_pkg

// File: rtl/delay_rx_fifo_mem.sv
// -----------------------------------------------------------------------------
// delay_rx_fifo_mem
// Simple dual-port register array: one synchronous write port, one
// asynchronous read port. Contents are not reset; validity is tracked by the
// controlling FIFO.
// Ports:
//   clk      : write clock
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   rd_addr  : read address
//   rd_data  : read data (combinational from rd_addr)
// -----------------------------------------------------------------------------
module delay_rx_fifo_mem
    import delay_pkg::*;
#(
    parameter int WIDTH = DEFAULT_SIG_DATA_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                        clk,
    input  logic                        wr_en,
    input  logic [ptr_width(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]            wr_data,
    input  logic [ptr_width(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]            rd_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Storage write; no reset so the array maps onto plain register/RAM cells.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule : delay_rx_fifo_mem

// File: rtl/delay_rx_fifo.sv
// -----------------------------------------------------------------------------
// delay_rx_fifo
// Receive FIFO at the output of a fixed-delay pipeline. The source cannot be
// stalled: a word arriving when the FIFO is full and nothing is being popped
// is dropped and the sticky overflow flag is raised. A full-cycle push that
// coincides with a pop is accepted.
// Ports:
//   clk         : clock, rising edge
//   reset       : asynchronous active-low reset of control state
//   clear       : synchronous flush (pointers, count, overflow); beats push/pop
//   in_valid    : Data_In valid this cycle
//   Data_In     : incoming payload
//   out_valid   : Data_Out holds the head entry
//   out_ready   : consumer accepts the head entry
//   Data_Out    : head payload, zero when out_valid is low
//   almost_full : occupancy >= AFULL_LEVEL (advice to upstream control)
//   overflow    : sticky, a word has been dropped
//   level       : live occupancy, only with DELAY_RX_FIFO_COUNT_EN defined
// Build option: define DELAY_RX_FIFO_COUNT_EN to add the 'level' output.
// -----------------------------------------------------------------------------
module delay_rx_fifo
    import delay_pkg::*;
#(
    parameter int SIG_DATA_WIDTH = DEFAULT_SIG_DATA_WIDTH,
    parameter int DEPTH          = DEFAULT_DEPTH,
    parameter int AFULL_LEVEL    = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      in_valid,
    input  logic [SIG_DATA_WIDTH-1:0] Data_In,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SIG_DATA_WIDTH-1:0] Data_Out,
    output logic                      almost_full,
    output logic                      overflow
`ifdef DELAY_RX_FIFO_COUNT_EN
    ,
    output logic [ptr_width(DEPTH):0] level
`endif
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_LEVEL);
    localparam logic [CNT_W-1:0] ZERO_CNT  = {CNT_W{1'b0}};
    localparam logic [PTR_W-1:0] ZERO_PTR  = {PTR_W{1'b0}};

    logic [PTR_W-1:0]          wr_ptr_r;
    logic [PTR_W-1:0]          rd_ptr_r;
    logic [CNT_W-1:0]          count_r;
    logic                      overflow_r;

    logic                      pop_s;
    logic                      push_s;
    logic                      drop_s;
    logic                      wr_en_s;
    logic [CNT_W-1:0]          count_nxt_s;
    logic [SIG_DATA_WIDTH-1:0] rd_data_s;

    // Handshake decode; a pop frees the slot a full-cycle push needs.
    always_comb begin
        pop_s   = 1'b0;
        push_s  = 1'b0;
        drop_s  = 1'b0;
        wr_en_s = 1'b0;
        if (count_r != ZERO_CNT) begin
            pop_s = out_ready;
        end else begin
            pop_s = 1'b0;
        end
        if (in_valid) begin
            push_s = (count_r != FULL_CNT) || pop_s;
            drop_s = (count_r == FULL_CNT) && !pop_s;
        end else begin
            push_s = 1'b0;
            drop_s = 1'b0;
        end
        // clear discards the incoming word as well as any pop
        if (clear) begin
            wr_en_s = 1'b0;
        end else begin
            wr_en_s = push_s;
        end
    end

    // Occupancy update: simultaneous push and pop leave it unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Control state: pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r   <= ZERO_PTR;
            rd_ptr_r   <= ZERO_PTR;
            count_r    <= ZERO_CNT;
            overflow_r <= 1'b0;
        end else if (clear) begin
            wr_ptr_r   <= ZERO_PTR;
            rd_ptr_r   <= ZERO_PTR;
            count_r    <= ZERO_CNT;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_nxt_s;
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    delay_rx_fifo_mem #(
        .WIDTH (SIG_DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en_s),
        .wr_addr (wr_ptr_r),
        .wr_data (Data_In),
        .rd_addr (rd_ptr_r),
        .rd_data (rd_data_s)
    );

    // All outputs depend only on registered state (and the stored array),
    // so there is no path from Data_In to Data_Out within a cycle.
    assign out_valid   = (count_r != ZERO_CNT);
    assign Data_Out    = out_valid ? rd_data_s : {SIG_DATA_WIDTH{1'b0}};
    assign almost_full = (count_r >= AFULL_CNT);
    assign overflow    = overflow_r;

`ifdef DELAY_RX_FIFO_COUNT_EN
    assign level = count_r;
`endif

endmodule : delay_rx_fifo

// File: doc/delay_rx_fifo.md
DELAY_RX_FIFO -- requirements
Module: delay_rx_fifo

Interface
REQ-001 The block SHALL have parameter SIG_DATA_WIDTH, default 16, the payload width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, the number of entries; legal values are powers of two, 2 to 64.
REQ-003 The block SHALL have parameter AFULL_LEVEL, default 6, the occupancy at which almost_full asserts; legal range is 1 to DEPTH.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-low reset; the block SHALL enter reset while reset=0, independent of clk.
REQ-006 Port clear, input, 1 bit: synchronous flush.
REQ-007 Port in_valid, input, 1 bit: Data_In is valid this cycle; the source has no stall path.
REQ-008 Port Data_In, input, SIG_DATA_WIDTH bits: payload arriving from the end of a fixed delay pipeline.
REQ-009 Port out_valid, output, 1 bit: Data_Out holds the head entry.
REQ-010 Port out_ready, input, 1 bit: the consumer accepts the head entry this cycle.
REQ-011 Port Data_Out, output, SIG_DATA_WIDTH bits: head payload.
REQ-012 Port almost_full, output, 1 bit: occupancy >= AFULL_LEVEL; it is backpressure advice to upstream control.
REQ-013 Port overflow, output, 1 bit: sticky flag set when a word has been dropped.

Function
REQ-014 Occupancy SHALL be a counter $clog2(DEPTH)+1 bits wide, range 0 to DEPTH; the read and write pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-015 Push SHALL occur when in_valid=1 and either count<DEPTH or a pop occurs in the same cycle.
REQ-016 Pop SHALL occur when out_valid=1 and out_ready=1.
REQ-017 Simultaneous push and pop SHALL leave count unchanged, including at count=DEPTH, where a full-cycle push is accepted and not dropped.
REQ-018 When in_valid=1, count=DEPTH and there is no pop, the word SHALL be discarded, overflow SHALL set on the next edge, and storage SHALL remain unchanged.
REQ-019 out_valid SHALL equal (count!=0) and SHALL be derived from registered state only.
REQ-020 Data_Out SHALL present the head entry when out_valid=1 and SHALL be all zeros when out_valid=0.
REQ-021 Latency SHALL be 1 cycle: a word pushed into an empty FIFO at edge N is visible at out_valid/Data_Out after edge N; there is no combinational bypass from Data_In to Data_Out.
REQ-022 While out_valid=1 and out_ready=0, Data_Out SHALL hold its value and ordering SHALL be strictly FIFO.
REQ-023 almost_full SHALL be registered-state derived: count >= AFULL_LEVEL.
REQ-024 clear=1 SHALL, on the next edge, zero the pointers, count and overflow; push and pop in the same cycle SHALL be ignored (clear wins).
REQ-025 Storage contents SHALL NOT require reset; only control state is reset.

Reset
REQ-026 While reset=0, count, the pointers and overflow SHALL be 0, so that out_valid=0, Data_Out=0 and almost_full=0.
REQ-027 Reset asserted mid-transfer SHALL discard all entries immediately; after release, the first push SHALL be the first word output.

Configuration
REQ-028 With macro DELAY_RX_FIFO_COUNT_EN defined, the block SHALL add output port level, $clog2(DEPTH)+1 bits, equal to the live count (0 in reset).
REQ-029 With DELAY_RX_FIFO_COUNT_EN undefined, port level SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-030 Shared package delay_pkg SHALL hold the default SIG_DATA_WIDTH and DEPTH constants and a function returning the pointer width for a given DEPTH.
REQ-031 Storage SHALL be a sub-module delay_rx_fifo_mem: a simple dual-port register array with one write and one asynchronous read, no reset; control logic stays in delay_rx_fifo.

Verification
REQ-032 Push 0x0001 to 0x0008 with out_ready=0 -> count=8, almost_full=1 from the sixth word, overflow=0; then out_ready=1 -> 0x0001 to 0x0008 in order, one per cycle, then out_valid=0 and Data_Out=0.
REQ-033 From full, push 0x00AA with no pop -> overflow=1 and the stored sequence is unchanged; push 0x00BB with a simultaneous pop -> 0x00BB is accepted, appears last, and count stays 8.
REQ-034 From empty, continuous in_valid with out_ready=1 for 20 words -> output equals input delayed by 1 cycle, count never exceeds 1, and the pointers wrap twice with no error.
REQ-035 Load 5 words, then assert reset=0 asynchronously mid-cycle -> out_valid and Data_Out drop to 0 before the next edge; after release, push 0x1234 -> first output is 0x1234.
REQ-036 Load 4 words and assert clear together with in_valid (0x5555) -> count=0 and overflow=0 next cycle, and 0x5555 is never output.
REQ-037 With DELAY_RX_FIFO_COUNT_EN defined, repeat REQ-032 -> level tracks 0 to 8 and back to 0 cycle-accurately.
